sar_signed_search: RTL and testbench

- Sequential successive-approximation search. Recovers an unknown N-bit two's-complement target value held outside the block.
- Source of information: a 1-bit "probe < target" answer from an external signed less-than comparator.
- This block drives the comparator's `a` operand (`probe`). It consumes the comparator's `out` (`lt`). The comparator's `b` operand is tied to the hidden target.
- Used for threshold calibration and as a self-checking companion to the signed comparator in the lab datapath.

---
 rtl/sar_signed_search.sv | 100 ++++++++++
 tb/tb_sar_signed_search.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_signed_search.sv
// Successive-approximation search that recovers a hidden N-bit signed target
// using only a 1-bit "probe < target" answer from an external comparator.
module sar_signed_search #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         lt,
    output logic [N-1:0] probe,
    output logic         probe_valid,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]  SIGN    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_TOP = IW'(N-1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE_MIN,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [N-1:0]  acc, acc_next;
    logic [N-1:0]  probe_next, result_next;
    logic [IW-1:0] idx, idx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            probe  <= '0;
            acc    <= '0;
            idx    <= IDX_TOP;
            result <= '0;
        end else begin
            state  <= state_next;
            probe  <= probe_next;
            acc    <= acc_next;
            idx    <= idx_next;
            result <= result_next;
        end
    end

    // acc is offset-binary: flipping the MSB converts it to the signed value.
    always_comb begin
        state_next  = state;
        probe_next  = probe;
        acc_next    = acc;
        idx_next    = idx;
        result_next = result;
        probe_valid = (state == S_PROBE_MIN) || (state == S_SEARCH);
        busy        = probe_valid;
        done        = (state == S_DONE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_PROBE_MIN;
                    probe_next = SIGN;
                    acc_next   = '0;
                end
            end
            S_PROBE_MIN: begin
                if (!lt) begin
                    result_next = SIGN;
                    state_next  = S_DONE;
                end else begin
                    state_next = S_SEARCH;
                    idx_next   = IDX_TOP;
                    probe_next = (acc | SIGN) ^ SIGN;
                end
            end
            S_SEARCH: begin
                if (lt) begin
                    acc_next = acc | (ONE << idx);
                end
                if (idx != '0) begin
                    idx_next   = idx - IDX_ONE;
                    probe_next = (acc_next | (ONE << (idx - IDX_ONE))) ^ SIGN;
                end else begin
                    // acc_next is the largest value below target, so +1 cannot wrap.
                    result_next = (acc_next ^ SIGN) + ONE;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sar_signed_search.sv
// Self-checking bench for sar_signed_search (N=8) with a behavioural
// comparator and a plain-arithmetic model of the expected probe sequence.
module tb_sar_signed_search;
    localparam int N = 8;

    logic         clk = 0;
    logic         rst;
    logic         start;
    logic         lt;
    logic [N-1:0] probe;
    logic         probe_valid;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [N-1:0] target;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;
    int overlap = 0;

    logic [N-1:0] probe_log[$];
    logic [N-1:0] exp_q[$];

    sar_signed_search #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .lt(lt),
        .probe(probe), .probe_valid(probe_valid), .busy(busy),
        .done(done), .result(result)
    );

    // Clock and comparator environment
    always #5 clk = ~clk;
    assign lt = $signed(probe) < $signed(target);

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (busy && done) overlap++;
    end

    // Reference: a signed lower bound that starts at the minimum and is raised
    // by each power-of-two step whose probe is still below the target.
    function automatic void build_expected(input int t);
        int base;
        int p;
        exp_q.delete();
        exp_q.push_back(8'h80);
        if (t == -128) return;
        base = -128;
        for (int k = N - 1; k >= 0; k--) begin
            p = base + (1 << k);
            exp_q.push_back(p[N-1:0]);
            if (p < t) base = p;
        end
    endfunction

    task automatic run_search(input logic [N-1:0] tgt, input bit hold, input int extra_at,
                              output int done_cyc, output logic [N-1:0] res);
        int cyc;
        bit started;
        cyc = 0;
        started = 0;
        done_cyc = -1;
        res = 'x;
        target = tgt;
        start = 1;
        probe_log.delete();
        for (int guard = 0; guard < 60; guard++) begin
            @(posedge clk);
            @(negedge clk);
            if (!started && busy) begin
                started = 1;
                cyc = 1;
            end else if (started) begin
                cyc++;
            end
            if (started) start = hold || (cyc == extra_at);
            if (started && probe_valid) probe_log.push_back(probe);
            if (started && done) begin
                done_cyc = cyc;
                res = result;
                break;
            end
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL search_timeout target=%h no done within bound", tgt);
        end
        start = hold;
    endtask

    task automatic check_search(input string name, input logic [N-1:0] tgt,
                                input int done_cyc, input logic [N-1:0] res);
        int exp_cyc;
        bit seq_ok;
        exp_cyc = ($signed(tgt) == -128) ? 2 : N + 2;
        build_expected($signed(tgt));
        total++;
        if (res !== tgt) begin
            bad++;
            $display("FAIL %s_result target=%h got=%h want=%h", name, tgt, res, tgt);
        end
        total++;
        if (done_cyc !== exp_cyc) begin
            bad++;
            $display("FAIL %s_latency target=%h got=%0d want=%0d", name, tgt, done_cyc, exp_cyc);
        end
        seq_ok = (probe_log.size() == exp_q.size());
        if (seq_ok)
            foreach (exp_q[i]) if (probe_log[i] !== exp_q[i]) seq_ok = 0;
        total++;
        if (!seq_ok) begin
            bad++;
            $display("FAIL %s_probes target=%h got_count=%0d want_count=%0d", name, tgt,
                     probe_log.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1;
        start = 0;
        target = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({probe, probe_valid, busy, done, result} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {probe, probe_valid, busy, done, result});
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_min();
        int c;
        logic [N-1:0] r;
        run_search(8'h80, 0, 0, c, r);
        check_search("min", 8'h80, c, r);
        total++;
        if (probe_log.size() !== 1) begin
            bad++;
            $display("FAIL min_probe_count got=%0d want=1", probe_log.size());
        end
    endtask

    task automatic test_max();
        int c;
        logic [N-1:0] r;
        logic [N-1:0] first4[4];
        first4 = '{8'h80, 8'h00, 8'h40, 8'h60};
        run_search(8'h7F, 0, 0, c, r);
        check_search("max", 8'h7F, c, r);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (probe_log.size() <= i || probe_log[i] !== first4[i]) begin
                bad++;
                $display("FAIL max_probe%0d got=%h want=%h", i,
                         (probe_log.size() > i) ? probe_log[i] : 8'hxx, first4[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int d0;
        logic [N-1:0] r;
        logic [N-1:0] tg[3];
        tg = '{8'h00, 8'hFF, 8'h81};
        @(negedge clk);
        d0 = done_pulses;
        for (int i = 0; i < 3; i++) begin
            run_search(tg[i], 1, 0, c, r);
            check_search("b2b", tg[i], c, r);
        end
        start = 0;
        repeat (3) @(negedge clk);
        total++;
        if (done_pulses - d0 !== 3) begin
            bad++;
            $display("FAIL b2b_done_pulses got=%0d want=3", done_pulses - d0);
        end
    endtask

    task automatic test_ignored_start();
        int c;
        logic [N-1:0] r;
        bit restarted;
        run_search(8'h05, 0, 4, c, r);
        check_search("ign", 8'h05, c, r);
        restarted = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) restarted = 1;
        end
        total++;
        if (restarted) begin
            bad++;
            $display("FAIL ign_no_restart got=busy want=idle");
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic [N-1:0] r;
        target = 8'd37;
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        total++;
        if ({probe, probe_valid, busy, done, result} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0", {probe, probe_valid, busy, done, result});
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_search(8'hFE, 0, 0, c, r);
        check_search("after_rst", 8'hFE, c, r);
    endtask

    task automatic test_sweep();
        int c;
        int j;
        int o0;
        logic [N-1:0] r;
        logic [N-1:0] order[256];
        logic [N-1:0] tmp;
        for (int i = 0; i < 256; i++) order[i] = i[N-1:0];
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        o0 = overlap;
        for (int i = 0; i < 256; i++) begin
            run_search(order[i], 0, 0, c, r);
            check_search("sweep", order[i], c, r);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        total++;
        if (overlap !== o0) begin
            bad++;
            $display("FAIL sweep_busy_done_overlap got=%0d want=0", overlap - o0);
        end
    endtask

    initial begin
        test_reset();
        test_min();
        test_max();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
